// File: rtl/dmem_pkg.sv
// Shared types and default widths for the data-memory arbiter.
// The widths match the arbiter parameter defaults.
package dmem_pkg;

    localparam int DMEM_ADDR_W = 10;
    localparam int DMEM_DATA_W = 32;
    localparam int DMEM_BE_W   = DMEM_DATA_W / 8;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_LOCK0 = 2'd1,
        ARB_LOCK1 = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic                   req;
        logic                   lock;
        logic [DMEM_BE_W-1:0]   we;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] wdata;
    } dmem_req_t;

    typedef struct packed {
        logic                   gnt;
        logic                   rvalid;
        logic [DMEM_DATA_W-1:0] rdata;
    } dmem_resp_t;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input round-robin picker: on a tie the master that was not granted last wins.
// last_i=1 means master 1 was granted most recently.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    assign gnt_o[0] = req_i[0] & (~req_i[1] | last_i);
    assign gnt_o[1] = req_i[1] & (~req_i[0] | ~last_i);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter with bus lock and lock timeout in front of a 1-cycle data memory.
// Optional grant/conflict performance counters are enabled by defining DMEM_ARB_PERF_EN.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W   = DMEM_ADDR_W,
    parameter int DATA_W   = DMEM_DATA_W,
    parameter int LOCK_MAX = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_req,
    input  logic                  m0_lock,
    input  logic [DATA_W/8-1:0]   m0_we,
    input  logic [ADDR_W-1:0]     m0_addr,
    input  logic [DATA_W-1:0]     m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_W-1:0]     m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_lock,
    input  logic [DATA_W/8-1:0]   m1_we,
    input  logic [ADDR_W-1:0]     m1_addr,
    input  logic [DATA_W-1:0]     m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_W-1:0]     m1_rdata,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_we,
    input  logic [DATA_W-1:0]     mem_rdata
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]           perf_gnt0,
    output logic [31:0]           perf_gnt1,
    output logic [31:0]           perf_conflict
`endif
);

    localparam int CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) + 1 : 1;

    arb_state_t        state_q;
    logic              last_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              rd_pend_q, rd_pend_d;
    logic              rd_owner_q, rd_owner_d;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;
    logic [1:0]        req_masked;
    logic [1:0]        gnt;
    logic              timeout;

    // The lock owner is the only master the picker can see while locked.
    always_comb begin
        req_masked = {m1_req, m0_req};
        case (state_q)
            ARB_LOCK0: req_masked = {1'b0, m0_req};
            ARB_LOCK1: req_masked = {m1_req, 1'b0};
            default:   req_masked = {m1_req, m0_req};
        endcase
    end

    rr_arb2 u_rr_arb2 (
        .req_i  (req_masked),
        .last_i (last_q),
        .gnt_o  (gnt)
    );

    assign m0_gnt = gnt[0];
    assign m1_gnt = gnt[1];

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = '0;
        if (gnt[0]) begin
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
            mem_we    = m0_we;
        end else if (gnt[1]) begin
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
            mem_we    = m1_we;
        end
    end

    // Counter value LOCK_MAX-1 is reached at the edge ending this cycle.
    assign timeout = (LOCK_MAX != 0) && ((int'(cnt_q) + 1) >= (LOCK_MAX - 1));

    assign rd_pend_d  = (|gnt) && (mem_we == '0);
    assign rd_owner_d = gnt[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            if (gnt[0]) begin
                last_q <= 1'b0;
            end else if (gnt[1]) begin
                last_q <= 1'b1;
            end
            case (state_q)
                ARB_IDLE: begin
                    cnt_q <= '0;
                    if (gnt[0] && m0_lock) begin
                        state_q <= ARB_LOCK0;
                    end else if (gnt[1] && m1_lock) begin
                        state_q <= ARB_LOCK1;
                    end
                end
                ARB_LOCK0: begin
                    if (!m0_lock || timeout) begin
                        state_q <= ARB_IDLE;
                        last_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ARB_LOCK1: begin
                    if (!m1_lock || timeout) begin
                        state_q <= ARB_IDLE;
                        last_q  <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
            if (m0_rvalid) begin
                rdata0_q <= mem_rdata;
            end
            if (m1_rvalid) begin
                rdata1_q <= mem_rdata;
            end
        end
    end

    // Read data passes straight from the macro in the response cycle, then is held.
    assign m0_rvalid = rd_pend_q & ~rd_owner_q;
    assign m1_rvalid = rd_pend_q &  rd_owner_q;
    assign m0_rdata  = m0_rvalid ? mem_rdata : rdata0_q;
    assign m1_rdata  = m1_rvalid ? mem_rdata : rdata1_q;

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_gnt0_q, perf_gnt1_q, perf_conflict_q;
    logic        conflict;

    assign conflict = (m0_req & ~gnt[0]) | (m1_req & ~gnt[1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_gnt0_q     <= '0;
            perf_gnt1_q     <= '0;
            perf_conflict_q <= '0;
        end else begin
            if (gnt[0] && (perf_gnt0_q != '1)) begin
                perf_gnt0_q <= perf_gnt0_q + 32'd1;
            end
            if (gnt[1] && (perf_gnt1_q != '1)) begin
                perf_gnt1_q <= perf_gnt1_q + 32'd1;
            end
            if (conflict && (perf_conflict_q != '1)) begin
                perf_conflict_q <= perf_conflict_q + 32'd1;
            end
        end
    end

    assign perf_gnt0     = perf_gnt0_q;
    assign perf_gnt1     = perf_gnt1_q;
    assign perf_conflict = perf_conflict_q;
`endif

endmodule
